// File: rtl/store_arb_pkg.sv
// Shared definitions for the two-requester store arbiter.
// The state encoding lives here so that other blocks can decode
// the arbiter state without duplicating the constants.
package store_arb_pkg;

    // Number of requesters the arbiter serves
    localparam int NUM_REQ = 2;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/store_reg.sv
// Shared storage register with load enable and synchronous clear.
module store_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset wins over a coinciding load so a write never survives reset
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/store_arbiter.sv
// Two-requester round-robin arbiter guarding a shared storage register.
// A granted requester may write the register while it keeps req high.
// A grant is forcibly released after HOLD_MAX cycles only if the other
// requester is waiting. Every release passes through a one-cycle GAP,
// and the round-robin pointer then favours the other requester.
module store_arbiter
    import store_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       we,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] q,
    output logic             owner,
    output logic             valid,
    output logic             busy
);

    // Counter must be able to hold HOLD_MAX itself
    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(HOLD_MAX);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    arb_state_t      state;
    logic            ptr;
    logic [CW-1:0]   hold_cnt;

    logic            cur;
    logic            own_req;
    logic            oth_req;
    logic            wr_en;
    logic            wr_sel;
    logic [WIDTH-1:0] wr_data;

    // Decode the current grant holder and the write request it carries
    always_comb begin
        cur     = gnt[1];
        own_req = cur ? req[1] : req[0];
        oth_req = cur ? req[0] : req[1];
        wr_sel  = cur;
        wr_en   = (state == GRANT) && ((gnt & req & we) != 2'b00);
        wr_data = cur ? wdata1 : wdata0;
    end

    // Arbiter FSM with registered grant, busy, pointer and hold counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            busy     <= 1'b0;
            ptr      <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        state    <= GRANT;
                        busy     <= 1'b1;
                        hold_cnt <= CNT_ONE;
                        if (req == 2'b11) begin
                            gnt <= ptr ? 2'b10 : 2'b01;
                        end else begin
                            gnt <= req;
                        end
                    end
                end
                GRANT: begin
                    if (!own_req || (hold_cnt == HOLD_LIMIT && oth_req)) begin
                        state    <= GAP;
                        gnt      <= 2'b00;
                        ptr      <= ~cur;
                        hold_cnt <= '0;
                    end else if (hold_cnt < HOLD_LIMIT) begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end
                end
                GAP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    gnt      <= 2'b00;
                    busy     <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // Track which requester last wrote q and whether q has ever been written
    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= 1'b0;
            valid <= 1'b0;
        end else if (wr_en) begin
            owner <= wr_sel;
            valid <= 1'b1;
        end
    end

    store_reg #(
        .WIDTH(WIDTH)
    ) u_store_reg (
        .clk   (clk),
        .reset (reset),
        .ld    (wr_en),
        .d     (wr_data),
        .q     (q)
    );

endmodule

// File: doc/store_arbiter.md
STORE_ARBITER -- requirements
Module: store_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, storage register and write-data width.
REQ-002 SHALL have parameter HOLD_MAX, default 4, grant cycles before a contested grant is forcibly released.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  2  request from requester i, held high until done.
REQ-006 SHALL have port we  input  2  write strobe from requester i; honoured only while granted.
REQ-007 SHALL have port wdata0  input  WIDTH  write data of requester 0.
REQ-008 SHALL have port wdata1  input  WIDTH  write data of requester 1.
REQ-009 SHALL have port gnt  output  2  registered one-hot grant; never both bits high.
REQ-010 SHALL have port q  output  WIDTH  shared storage register contents.
REQ-011 SHALL have port owner  output  1  index of requester that last wrote q.
REQ-012 SHALL have port valid  output  1  high once q has been written since reset.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, GAP; all outputs registered.
REQ-015 IDLE: at an edge with any req high, SHALL enter GRANT and assert gnt for the selected requester, visible the cycle after req is sampled (1-cycle grant latency).
REQ-016 Single request in IDLE SHALL be granted regardless of priority pointer.
REQ-017 Simultaneous requests in IDLE SHALL be granted to the requester named by the round-robin pointer (reset value 0).
REQ-018 GRANT: at each edge with gnt[i] high, req[i] high and we[i] high, q SHALL load wdata_i and owner SHALL load i, visible next cycle; valid SHALL be set.
REQ-019 we from the non-granted requester, or we without req, SHALL be ignored; q unchanged.
REQ-020 GRANT: hold counter SHALL count grant cycles, saturating at HOLD_MAX.
REQ-021 GRANT: req[i] low at an edge SHALL cause release: gnt cleared next cycle, state GAP.
REQ-022 GRANT: counter equal to HOLD_MAX and other requester's req high SHALL force release the same way; a write with we[i] at that edge still completes.
REQ-023 Counter at HOLD_MAX with other req low SHALL keep grant indefinitely.
REQ-024 On every release the pointer SHALL be set to the other requester; counter SHALL clear.
REQ-025 GAP SHALL last exactly one cycle with gnt = 0, then IDLE; req during GAP is sampled in IDLE next cycle.
REQ-026 Consecutive grants SHALL therefore be separated by at least two gnt-low cycles (GAP plus IDLE sampling).
REQ-027 q, owner, valid SHALL hold their values through IDLE and GAP.

Reset
REQ-028 reset high at an edge SHALL force state IDLE, gnt = 0, q = 0, owner = 0, valid = 0, busy = 0, pointer = 0, counter = 0, visible next cycle.
REQ-029 reset SHALL dominate: a write or grant coinciding with reset SHALL not take effect, including mid-GRANT.

Structure
REQ-030 State encoding constants (IDLE, GRANT, GAP) SHALL live in a shared package store_arb_pkg; WIDTH and HOLD_MAX remain module parameters.
REQ-031 The storage register with load enable SHALL be a sub-module named store_reg (clk, reset, ld, d, q); the arbiter FSM, pointer and counter remain in store_arbiter.

Verification
REQ-032 Reset then req=01, we=01, wdata0=8'hA5 -> gnt=01 one cycle later, q=8'hA5, owner=0, valid=1 the cycle after the write.
REQ-033 req=11 from IDLE after reset -> gnt=01; drop req[0] -> GAP, then gnt=10; next simultaneous request after release goes to requester 0.
REQ-034 req0 held, req1 high, HOLD_MAX=4 -> gnt=01 for exactly 4 cycles, then forced release, then gnt=10.
REQ-035 Granted 0, we=10 with wdata1=8'h3C -> q unchanged, owner unchanged.
REQ-036 Reset asserted in GRANT cycle with we=01, wdata0=8'hFF -> next cycle gnt=00, q=8'h00, valid=0, busy=0.
REQ-037 Only req0 held 10 cycles, req1 low -> gnt=01 continuously, no release.
